// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: op codes, FSM states, data width.
// WIDTH comes from the global `WIDTH macro (common.h); a fallback keeps standalone builds working.
`ifndef WIDTH
`define WIDTH 16
`endif

package stack_ctrl_pkg;

    localparam int unsigned WIDTH = `WIDTH;
    localparam int unsigned OP_W  = 2;

    localparam logic [OP_W-1:0] OP_NOP     = 2'b00;
    localparam logic [OP_W-1:0] OP_PUSH    = 2'b01;
    localparam logic [OP_W-1:0] OP_POP     = 2'b10;
    localparam logic [OP_W-1:0] OP_REPLACE = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/stack.sv
// J2 dual-address stack memory: combinational read port, synchronous write port.
// Contents are never reset.
module stack
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic [DEPTH-1:0] read_address,
    output logic [WIDTH-1:0] read_data,
    input  logic             write_enable,
    input  logic [DEPTH-1:0] write_address,
    input  logic [WIDTH-1:0] write_data
);

    localparam int unsigned ENTRIES = 2 ** DEPTH;

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop controller for a J2 stack: owns pointer, count, RUN/HALT FSM and error flags.
// Optional STACK_HIGH_WATER_EN adds a high_water output (max count since reset/flush).
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             active_low_reset,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] push_data,
    input  logic             flush,
    input  logic             err_clear,
    output logic [WIDTH-1:0] top,
    output logic             top_valid,
    output logic             full,
    output logic             empty,
    output logic [DEPTH:0]   count,
`ifdef STACK_HIGH_WATER_EN
    output logic [DEPTH:0]   high_water,
`endif
    output logic             overflow,
    output logic             underflow,
    output logic             halted
);

    localparam logic [DEPTH:0]   CAPACITY = (DEPTH+1)'(1) << DEPTH;
    localparam logic [DEPTH-1:0] SP_RESET = '1;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] sp_q, sp_d;
    logic [DEPTH:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             write_enable_c;
    logic [DEPTH-1:0] write_address_c;
    logic [WIDTH-1:0] read_data_c;
    logic             full_c, empty_c;

    assign full_c  = (count_q == CAPACITY);
    assign empty_c = (count_q == '0);

    // State register
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            state_q     <= ST_RUN;
            sp_q        <= SP_RESET;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state, pointer/count update and memory write control
    always_comb begin
        state_d         = state_q;
        sp_d            = sp_q;
        count_d         = count_q;
        overflow_d      = overflow_q;
        underflow_d     = underflow_q;
        write_enable_c  = 1'b0;
        write_address_c = sp_q;

        case (state_q)
            ST_RUN: begin
                if (!flush) begin
                    case (op)
                        OP_PUSH: begin
                            if (full_c) begin
                                overflow_d = 1'b1;
                                state_d    = ST_HALT;
                            end else begin
                                write_enable_c  = 1'b1;
                                write_address_c = sp_q + DEPTH'(1);
                                sp_d            = sp_q + DEPTH'(1);
                                count_d         = count_q + (DEPTH+1)'(1);
                            end
                        end
                        OP_POP: begin
                            if (empty_c) begin
                                underflow_d = 1'b1;
                                state_d     = ST_HALT;
                            end else begin
                                sp_d    = sp_q - DEPTH'(1);
                                count_d = count_q - (DEPTH+1)'(1);
                            end
                        end
                        OP_REPLACE: begin
                            if (empty_c) begin
                                underflow_d = 1'b1;
                                state_d     = ST_HALT;
                            end else begin
                                write_enable_c = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: begin
                if (err_clear) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // flush wins over any op but leaves FSM and flags alone
        if (flush) begin
            sp_d           = SP_RESET;
            count_d        = '0;
            write_enable_c = 1'b0;
        end
    end

`ifdef STACK_HIGH_WATER_EN
    logic [DEPTH:0] high_water_q;

    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            high_water_q <= '0;
        end else if (flush) begin
            high_water_q <= '0;
        end else if (count_d > high_water_q) begin
            high_water_q <= count_d;
        end
    end

    assign high_water = high_water_q;
`endif

    stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clock         (clock),
        .read_address  (sp_q),
        .read_data     (read_data_c),
        .write_enable  (write_enable_c),
        .write_address (write_address_c),
        .write_data    (push_data)
    );

    assign top       = empty_c ? '0 : read_data_c;
    assign top_valid = !empty_c;
    assign full      = full_c;
    assign empty     = empty_c;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (DEPTH=2): directed scenarios plus random ops against a queue model.
// Covers the high_water output when STACK_HIGH_WATER_EN is defined.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CAP   = 2 ** DEPTH;

    logic             clock;
    logic             active_low_reset;
    logic [1:0]       op;
    logic [WIDTH-1:0] push_data;
    logic             flush;
    logic             err_clear;
    logic [WIDTH-1:0] top;
    logic             top_valid, full, empty;
    logic [DEPTH:0]   count;
`ifdef STACK_HIGH_WATER_EN
    logic [DEPTH:0]   high_water;
`endif
    logic             overflow, underflow, halted;

    stack_ctrl #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .active_low_reset (active_low_reset),
        .op               (op),
        .push_data        (push_data),
        .flush            (flush),
        .err_clear        (err_clear),
        .top              (top),
        .top_valid        (top_valid),
        .full             (full),
        .empty            (empty),
        .count            (count),
`ifdef STACK_HIGH_WATER_EN
        .high_water       (high_water),
`endif
        .overflow         (overflow),
        .underflow        (underflow),
        .halted           (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue of entries plus flags
    logic [WIDTH-1:0] mq[$];
    bit               m_halt, m_ovf, m_udf;
    int               m_hw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_halt = 0; m_ovf = 0; m_udf = 0; m_hw = 0;
    endtask

    task automatic model_step(input logic [1:0] o, input logic [WIDTH-1:0] d,
                              input logic fl, input logic ec);
        if (m_halt && ec) begin
            m_halt = 0; m_ovf = 0; m_udf = 0;
        end else if (!m_halt && !fl) begin
            case (o)
                OP_PUSH:    if (mq.size() == CAP) begin m_ovf = 1; m_halt = 1; end
                            else mq.push_back(d);
                OP_POP:     if (mq.size() == 0) begin m_udf = 1; m_halt = 1; end
                            else void'(mq.pop_back());
                OP_REPLACE: if (mq.size() == 0) begin m_udf = 1; m_halt = 1; end
                            else mq[mq.size()-1] = d;
                default: ;
            endcase
        end
        if (fl) begin
            mq.delete();
            m_hw = 0;
        end
        if (mq.size() > m_hw) m_hw = mq.size();
    endtask

    task automatic check_all(input string where);
        logic [WIDTH-1:0] exp_top;
        exp_top = (mq.size() != 0) ? mq[mq.size()-1] : '0;
        check({where, ".top"},       32'(top),       32'(exp_top));
        check({where, ".count"},     32'(count),     32'(mq.size()));
        check({where, ".empty"},     32'(empty),     32'(mq.size() == 0));
        check({where, ".full"},      32'(full),      32'(mq.size() == CAP));
        check({where, ".top_valid"}, 32'(top_valid), 32'(mq.size() != 0));
        check({where, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({where, ".underflow"}, 32'(underflow), 32'(m_udf));
        check({where, ".halted"},    32'(halted),    32'(m_halt));
`ifdef STACK_HIGH_WATER_EN
        check({where, ".high_water"}, 32'(high_water), 32'(m_hw));
`endif
    endtask

    task automatic step(input string where, input logic [1:0] o, input logic [WIDTH-1:0] d,
                        input logic fl, input logic ec);
        @(negedge clock);
        op = o; push_data = d; flush = fl; err_clear = ec;
        model_step(o, d, fl, ec);
        @(posedge clock);
        #1;
        check_all(where);
        op = OP_NOP; flush = 1'b0; err_clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 active_low_reset = 1'b0;
        #1 model_reset();
        check_all("reset");
        @(negedge clock);
        active_low_reset = 1'b1;
    endtask

    initial begin
        op = OP_NOP; push_data = '0; flush = 1'b0; err_clear = 1'b0;
        active_low_reset = 1'b0;
        model_reset();
        #12;
        check_all("por");
        @(negedge clock);
        active_low_reset = 1'b1;

        // Three pushes
        step("push1", OP_PUSH, WIDTH'('h11), 0, 0);
        step("push2", OP_PUSH, WIDTH'('h22), 0, 0);
        step("push3", OP_PUSH, WIDTH'('h33), 0, 0);
        check("push3.count_const", 32'(count), 32'd3);
        check("push3.top_const",   32'(top),   32'h33);

        // Fill, overflow, halted pop ignored, clear, pop
        do_reset();
        for (int i = 0; i < 4; i++) step("fill", OP_PUSH, WIDTH'('hA + i), 0, 0);
        step("ovf", OP_PUSH, WIDTH'('hE), 0, 0);
        check("ovf.top_const", 32'(top), 32'hD);
        step("halt_pop", OP_POP, '0, 0, 0);
        step("clr", OP_POP, '0, 0, 1);
        step("pop_after_clr", OP_POP, '0, 0, 0);
        check("pop_after_clr.top_const", 32'(top), 32'hC);

        // Underflow on pop and on replace
        do_reset();
        step("udf_pop", OP_POP, '0, 0, 0);
        do_reset();
        step("udf_repl", OP_REPLACE, WIDTH'('h5), 0, 0);
        step("udf_clr", OP_NOP, '0, 0, 1);
        check("udf_clr.top_const", 32'(top), 32'h0);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 4; i++) step("wrap_a", OP_PUSH, WIDTH'('h90 + i), 0, 0);
        for (int i = 0; i < 4; i++) step("wrap_b", OP_POP, '0, 0, 0);
        for (int i = 1; i <= 4; i++) step("wrap_c", OP_PUSH, WIDTH'(i), 0, 0);
        check("wrap.full_const", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) step("wrap_d", OP_POP, '0, 0, 0);

        // Replace on non-empty, push with flush
        step("repl_push", OP_PUSH, WIDTH'('h40), 0, 0);
        step("repl", OP_REPLACE, WIDTH'('h41), 0, 0);
        step("flush_push", OP_PUSH, WIDTH'('h77), 1, 0);
        check("flush_push.count_const", 32'(count), 32'd0);

        // Reset mid-stream with count 3
        for (int i = 0; i < 3; i++) step("mid", OP_PUSH, WIDTH'('h60 + i), 0, 0);
        do_reset();

        // High-water scenario (model tracks it; port checked when present)
        for (int i = 0; i < 3; i++) step("hw_push", OP_PUSH, WIDTH'(i + 1), 0, 0);
        step("hw_pop1", OP_POP, '0, 0, 0);
        step("hw_pop2", OP_POP, '0, 0, 0);
        step("hw_push4", OP_PUSH, WIDTH'('h9), 0, 0);
`ifdef STACK_HIGH_WATER_EN
        check("hw.const", 32'(high_water), 32'd3);
`endif
        step("hw_flush", OP_NOP, '0, 1, 0);

        // Random traffic including flush/err_clear combinations
        for (int n = 0; n < 3000; n++) begin
            logic [1:0]       ro;
            logic [WIDTH-1:0] rd;
            logic             rf, re;
            ro = 2'($urandom_range(0, 3));
            rd = WIDTH'($urandom);
            rf = ($urandom_range(0, 15) == 0);
            re = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            step("rand", ro, rd, rf, re);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
